// File: rtl/actuator_executor.sv
// -----------------------------------------------------------------------------
// actuator_executor
//
// Turns the navigation FSM's level commands (avancar / girar / remover) into
// timed actuation bursts for the differential-drive pipe robot. Each burst is
// followed by an all-off dead-time. Busy and done are reported back to the
// navigation side.
//
// Ports:
//   clockc2      in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   avancar      in   forward-step command (level)
//   girar        in   right-pivot turn command (level)
//   remover      in   debris-removal command (level)
//   motor_l_en   out  left motor enable
//   motor_l_dir  out  left motor direction, 1 = forward
//   motor_r_en   out  right motor enable
//   motor_r_dir  out  right motor direction, 1 = forward
//   brush_en     out  removal brush enable
//   busy         out  burst or dead-time in progress
//   done         out  one-cycle pulse on the final burst cycle
//   cmd_conflict out  one-cycle pulse: several commands high at acceptance
//   step_count   out  [15:0] completed forward steps (ACTUATOR_ODOMETER_EN only)
//   turn_count   out  [15:0] completed turns         (ACTUATOR_ODOMETER_EN only)
//
// Optional feature macro: ACTUATOR_ODOMETER_EN adds saturating step/turn
// odometer counters. They increment on the done cycle of a FWD or TURN burst.
// -----------------------------------------------------------------------------
module actuator_executor #(
    parameter int STEP_CYCLES  = 8,
    parameter int TURN_CYCLES  = 12,
    parameter int CLEAN_CYCLES = 20,
    parameter int DEAD_CYCLES  = 2,
    parameter int CNT_W        = 8
) (
    input  logic        clockc2,
    input  logic        reset,
    input  logic        avancar,
    input  logic        girar,
    input  logic        remover,
    output logic        motor_l_en,
    output logic        motor_l_dir,
    output logic        motor_r_en,
    output logic        motor_r_dir,
    output logic        brush_en,
    output logic        busy,
    output logic        done,
    output logic        cmd_conflict
`ifdef ACTUATOR_ODOMETER_EN
    ,
    output logic [15:0] step_count,
    output logic [15:0] turn_count
`endif
);

    // Elaboration-time parameter sanity checks.
    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    generate
        if (STEP_CYCLES < 1 || TURN_CYCLES < 1 || CLEAN_CYCLES < 1) begin : g_bad_len
            $error("actuator_executor: STEP/TURN/CLEAN_CYCLES must be >= 1");
        end
        if (DEAD_CYCLES < 0) begin : g_bad_dead
            $error("actuator_executor: DEAD_CYCLES must be >= 0");
        end
        if (longint'(STEP_CYCLES) > CNT_RANGE || longint'(TURN_CYCLES) > CNT_RANGE ||
            longint'(CLEAN_CYCLES) > CNT_RANGE || longint'(DEAD_CYCLES) > CNT_RANGE) begin : g_bad_cnt_w
            $error("actuator_executor: CNT_W too small for the configured cycle counts");
        end
    endgenerate

    // Counter load values are the length minus one. The counter then reaches 0
    // on the final cycle of a phase.
    localparam logic [CNT_W-1:0] STEP_LOAD  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAN_LOAD = CNT_W'(CLEAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_TURN,
        S_CLEAN,
        S_PAUSE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic w_accept;   // this edge behaves as an IDLE edge (commands sampled)
    logic w_any_cmd;
    logic w_multi_cmd;
    logic w_next_burst;
    logic w_next_done;
    logic w_next_conflict;

    logic r_motor_l_en, r_motor_l_dir, r_motor_r_en, r_motor_r_dir;
    logic r_brush_en, r_busy, r_done, r_cmd_conflict;

    assign w_any_cmd   = avancar | girar | remover;
    assign w_multi_cmd = (avancar & girar) | (avancar & remover) | (girar & remover);

    // Next-state / counter logic.
    // NOTE: every signal driven here gets a default value first. This way no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_accept = 1'b1;
            end
            S_FWD, S_TURN, S_CLEAN: begin
                if (r_cnt == '0) begin
                    if (DEAD_CYCLES > 0) begin
                        w_next_state = S_PAUSE;
                        w_next_cnt   = DEAD_LOAD;
                    end else begin
                        // With no dead-time the burst end edge is already the
                        // first IDLE edge. This lets a held command chain with
                        // no gap.
                        w_accept = 1'b1;
                    end
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            S_PAUSE: begin
                // The edge that ends the pause is the first IDLE edge.
                if (r_cnt == '0) begin
                    w_accept = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase

        // Command acceptance with priority remover > girar > avancar.
        if (w_accept) begin
            if (remover) begin
                w_next_state = S_CLEAN;
                w_next_cnt   = CLEAN_LOAD;
            end else if (girar) begin
                w_next_state = S_TURN;
                w_next_cnt   = TURN_LOAD;
            end else if (avancar) begin
                w_next_state = S_FWD;
                w_next_cnt   = STEP_LOAD;
            end else begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        end
    end

    // Outputs are decoded from the next state and then registered. The
    // actuation therefore appears in the cycle right after acceptance.
    assign w_next_burst    = (w_next_state == S_FWD) || (w_next_state == S_TURN) ||
                             (w_next_state == S_CLEAN);
    assign w_next_done     = w_next_burst && (w_next_cnt == '0);
    assign w_next_conflict = w_accept && w_multi_cmd;

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples pre-edge values, whatever the order of the statements.
    always_ff @(posedge clockc2) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_motor_l_en   <= 1'b0;
            r_motor_l_dir  <= 1'b0;
            r_motor_r_en   <= 1'b0;
            r_motor_r_dir  <= 1'b0;
            r_brush_en     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cmd_conflict <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_next_cnt;
            r_motor_l_en   <= (w_next_state == S_FWD) || (w_next_state == S_TURN);
            r_motor_l_dir  <= (w_next_state == S_FWD) || (w_next_state == S_TURN);
            r_motor_r_en   <= (w_next_state == S_FWD) || (w_next_state == S_TURN);
            r_motor_r_dir  <= (w_next_state == S_FWD);
            r_brush_en     <= (w_next_state == S_CLEAN);
            r_busy         <= (w_next_state != S_IDLE);
            r_done         <= w_next_done;
            r_cmd_conflict <= w_next_conflict;
        end
    end

    assign motor_l_en   = r_motor_l_en;
    assign motor_l_dir  = r_motor_l_dir;
    assign motor_r_en   = r_motor_r_en;
    assign motor_r_dir  = r_motor_r_dir;
    assign brush_en     = r_brush_en;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cmd_conflict = r_cmd_conflict;

`ifdef ACTUATOR_ODOMETER_EN
    logic [15:0] r_step_count;
    logic [15:0] r_turn_count;

    // The counts update on the same edge that raises done. The new count is
    // therefore visible during the done cycle. Both counts saturate.
    always_ff @(posedge clockc2) begin
        if (reset) begin
            r_step_count <= '0;
            r_turn_count <= '0;
        end else begin
            if (w_next_done && (w_next_state == S_FWD) && (r_step_count != 16'hFFFF)) begin
                r_step_count <= r_step_count + 16'd1;
            end
            if (w_next_done && (w_next_state == S_TURN) && (r_turn_count != 16'hFFFF)) begin
                r_turn_count <= r_turn_count + 16'd1;
            end
        end
    end

    assign step_count = r_step_count;
    assign turn_count = r_turn_count;
`endif

endmodule
